// File: rtl/dma_stream_engine.sv
// dma_stream_engine: single-outstanding Wishbone DMA master shared by an
// MM2S read channel (SDRAM -> stream) and an S2MM write channel
// (stream -> SDRAM), scheduled round-robin.
//
// state | meaning
// IDLE  | waiting for cfg_start
// SCHED | choose next bus transaction or detect completion
// RD    | Wishbone read in flight (we=0)
// WR    | Wishbone write in flight (we=1)
// FIN   | done pulse, back to IDLE
module dma_stream_engine #(
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [31:0]      cfg_src_adr,
  input  logic [31:0]      cfg_dst_adr,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  output logic             done,
  output logic             dma_stb_o,
  output logic             dma_cyc_o,
  output logic             dma_we_o,
  output logic [3:0]       dma_sel_o,
  output logic [31:0]      dma_adr_o,
  output logic [31:0]      dma_dat_o,
  input  logic             dma_ack_i,
  input  logic [31:0]      dma_dat_i,
  output logic [31:0]      mm2s_tdata,
  output logic             mm2s_tvalid,
  input  logic             mm2s_tready,
  output logic             mm2s_tlast,
  input  logic [31:0]      s2mm_tdata,
  input  logic             s2mm_tvalid,
  output logic             s2mm_tready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic CH_READ  = 1'b0;
  localparam logic CH_WRITE = 1'b1;

  typedef enum logic [2:0] {IDLE, SCHED, RD, WR, FIN} state_t;

  state_t           state;
  logic [31:0]      src_adr, dst_adr;
  logic [LEN_W-1:0] len, rd_issued, wr_done, wr_accepted, sent_cnt;
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [31:0]      wbuf;
  logic             wbuf_full;
  logic             rr_last;

  logic start_go, fifo_push, fifo_pop, wbuf_load, wbuf_clear;
  logic read_ok, write_ok, all_done;

  assign start_go   = (state == IDLE) && cfg_start;
  assign fifo_push  = (state == RD) && dma_ack_i;
  assign fifo_pop   = mm2s_tvalid && mm2s_tready;
  assign wbuf_load  = s2mm_tvalid && s2mm_tready;
  assign wbuf_clear = (state == WR) && dma_ack_i;

  // Only one transaction can be outstanding and none is while in SCHED,
  // so FIFO occupancy alone bounds the read credit.
  assign read_ok  = (rd_issued < len) && (fifo_cnt < CNT_W'(FIFO_DEPTH));
  assign write_ok = wbuf_full;
  assign all_done = (rd_issued == len) && (wr_done == len) && (fifo_cnt == '0);

  assign mm2s_tvalid = (fifo_cnt != '0);
  assign mm2s_tdata  = mm2s_tvalid ? fifo_mem[rd_ptr] : 32'h0;
  assign mm2s_tlast  = mm2s_tvalid && (sent_cnt == len - LEN_W'(1));
  assign s2mm_tready = busy && !wbuf_full && (wr_accepted < len);

  // Control FSM: scheduling, Wishbone master registers, busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      dma_stb_o <= 1'b0;
      dma_cyc_o <= 1'b0;
      dma_we_o  <= 1'b0;
      dma_sel_o <= 4'h0;
      dma_adr_o <= 32'h0;
      dma_dat_o <= 32'h0;
      src_adr   <= 32'h0;
      dst_adr   <= 32'h0;
      len       <= '0;
      rd_issued <= '0;
      wr_done   <= '0;
      rr_last   <= CH_WRITE;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            src_adr   <= cfg_src_adr;
            dst_adr   <= cfg_dst_adr;
            len       <= cfg_len;
            rd_issued <= '0;
            wr_done   <= '0;
            busy      <= 1'b1;
            state     <= SCHED;
          end
        end
        SCHED: begin
          if (all_done) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else if (read_ok && (!write_ok || rr_last == CH_WRITE)) begin
            dma_stb_o <= 1'b1;
            dma_cyc_o <= 1'b1;
            dma_we_o  <= 1'b0;
            dma_sel_o <= 4'hF;
            dma_adr_o <= src_adr + (32'(rd_issued) << 2);
            rr_last   <= CH_READ;
            state     <= RD;
          end else if (write_ok) begin
            dma_stb_o <= 1'b1;
            dma_cyc_o <= 1'b1;
            dma_we_o  <= 1'b1;
            dma_sel_o <= 4'hF;
            dma_adr_o <= dst_adr + (32'(wr_done) << 2);
            dma_dat_o <= wbuf;
            rr_last   <= CH_WRITE;
            state     <= WR;
          end
        end
        RD: begin
          if (dma_ack_i) begin
            dma_stb_o <= 1'b0;
            dma_cyc_o <= 1'b0;
            rd_issued <= rd_issued + LEN_W'(1);
            state     <= SCHED;
          end
        end
        WR: begin
          if (dma_ack_i) begin
            dma_stb_o <= 1'b0;
            dma_cyc_o <= 1'b0;
            wr_done   <= wr_done + LEN_W'(1);
            state     <= SCHED;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stream-side bookkeeping: read FIFO pointers, write buffer, beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      wbuf        <= 32'h0;
      wbuf_full   <= 1'b0;
      wr_accepted <= '0;
      sent_cnt    <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (wbuf_load) begin
        wbuf      <= s2mm_tdata;
        wbuf_full <= 1'b1;
      end else if (wbuf_clear) begin
        wbuf_full <= 1'b0;
      end
      if (start_go) begin
        wr_accepted <= '0;
        sent_cnt    <= '0;
      end else begin
        if (wbuf_load) wr_accepted <= wr_accepted + LEN_W'(1);
        if (fifo_pop)  sent_cnt    <= sent_cnt + LEN_W'(1);
      end
    end
  end

  // Read FIFO storage; contents need no reset because tvalid gates them.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= dma_dat_i;
  end

endmodule

// File: tb/tb_dma_stream_engine.sv
// Directed bench for dma_stream_engine: Wishbone slave model with
// programmable ack delay, MM2S sink and S2MM source.
module tb_dma_stream_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_src_adr = 32'h0;
  logic [31:0] cfg_dst_adr = 32'h0;
  logic [15:0] cfg_len = 16'h0;
  logic        busy, done;
  logic        dma_stb_o, dma_cyc_o, dma_we_o;
  logic [3:0]  dma_sel_o;
  logic [31:0] dma_adr_o, dma_dat_o;
  logic        dma_ack_i = 1'b0;
  logic [31:0] dma_dat_i = 32'h0;
  logic [31:0] mm2s_tdata;
  logic        mm2s_tvalid, mm2s_tlast;
  logic        mm2s_tready = 1'b0;
  logic [31:0] s2mm_tdata = 32'h0;
  logic        s2mm_tvalid = 1'b0;
  logic        s2mm_tready;

  always #5 clk = ~clk;

  dma_stream_engine #(.LEN_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_src_adr(cfg_src_adr),
    .cfg_dst_adr(cfg_dst_adr), .cfg_len(cfg_len), .busy(busy), .done(done),
    .dma_stb_o(dma_stb_o), .dma_cyc_o(dma_cyc_o), .dma_we_o(dma_we_o),
    .dma_sel_o(dma_sel_o), .dma_adr_o(dma_adr_o), .dma_dat_o(dma_dat_o),
    .dma_ack_i(dma_ack_i), .dma_dat_i(dma_dat_i), .mm2s_tdata(mm2s_tdata),
    .mm2s_tvalid(mm2s_tvalid), .mm2s_tready(mm2s_tready), .mm2s_tlast(mm2s_tlast),
    .s2mm_tdata(s2mm_tdata), .s2mm_tvalid(s2mm_tvalid), .s2mm_tready(s2mm_tready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // slave model state (written only by the slave process, except settings)
  int          ack_delay = 0;
  logic [31:0] rd_src = 32'h0, rd_base = 32'h0;
  int          wait_cnt = 0;
  bit          in_txn = 1'b0;
  logic [31:0] cap_adr = 32'h0, cap_dat = 32'h0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_sel = 4'h0;
  logic [31:0] log_adr [128];
  logic [31:0] log_dat [128];
  logic        log_we  [128];
  logic [3:0]  log_sel [128];
  int          log_wait[128];
  int          log_n = 0;
  int          prot_viol = 0;

  // monitor state
  logic [31:0] rx_dat [128];
  logic        rx_last[128];
  int          rx_n = 0, done_cnt = 0, stb_seen = 0, tvalid_seen = 0;

  // source state
  logic [31:0] s_words[16];
  int          s_n = 0, s_gen = 0, s_seen = 0, s_idx = 0;
  bit          will_fire = 1'b0;

  // per-test baselines
  int lb = 0, rb = 0, db = 0, pb = 0, sb = 0, vb = 0;

  // Wishbone slave: checks hold-stability and inter-transaction gap, logs, acks.
  initial forever begin
    @(negedge clk);
    if (dma_ack_i) begin
      dma_ack_i = 1'b0;
      if (dma_stb_o) prot_viol++;
    end else if (dma_stb_o) begin
      if (!dma_cyc_o) prot_viol++;
      if (dma_we_o && s2mm_tready) prot_viol++;
      if (!in_txn) begin
        in_txn = 1'b1; wait_cnt = 0;
        cap_adr = dma_adr_o; cap_dat = dma_dat_o; cap_we = dma_we_o; cap_sel = dma_sel_o;
      end else if (dma_adr_o !== cap_adr || dma_we_o !== cap_we || dma_sel_o !== cap_sel ||
                   (dma_we_o && dma_dat_o !== cap_dat)) begin
        prot_viol++;
      end
      if (wait_cnt < ack_delay) begin
        wait_cnt++;
      end else begin
        dma_ack_i = 1'b1;
        dma_dat_i = dma_we_o ? 32'h0 : rd_base + ((dma_adr_o - rd_src) >> 2);
        if (log_n < 128) begin
          log_adr[log_n] = dma_adr_o; log_dat[log_n] = dma_dat_o;
          log_we[log_n] = dma_we_o; log_sel[log_n] = dma_sel_o; log_wait[log_n] = wait_cnt;
          log_n++;
        end
        in_txn = 1'b0;
      end
    end else begin
      in_txn = 1'b0;
    end
  end

  // Output monitor: done pulses, activity flags, MM2S beats.
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (dma_stb_o) stb_seen++;
    if (mm2s_tvalid) tvalid_seen++;
    if (mm2s_tvalid && mm2s_tready && rx_n < 128) begin
      rx_dat[rx_n] = mm2s_tdata; rx_last[rx_n] = mm2s_tlast; rx_n++;
    end
  end

  // S2MM source: presents s_words in order, advancing after each accepted beat.
  initial forever begin
    @(negedge clk);
    if (s_gen != s_seen) begin
      s_seen = s_gen; s_idx = 0; will_fire = 1'b0;
    end else if (will_fire) begin
      s_idx++;
    end
    if (s_idx < s_n) begin
      s2mm_tvalid = 1'b1; s2mm_tdata = s_words[s_idx];
    end else begin
      s2mm_tvalid = 1'b0; s2mm_tdata = 32'h0;
    end
    will_fire = s2mm_tvalid && s2mm_tready && !rst;
  end

  task automatic drive_pt();
    @(posedge clk); #2;
  endtask

  task automatic mark();
    lb = log_n; rb = rx_n; db = done_cnt; pb = prot_viol; sb = stb_seen; vb = tvalid_seen;
  endtask

  task automatic load_src(int n, logic [31:0] base);
    for (int i = 0; i < n; i++) s_words[i] = base + 32'(i);
    s_n = n;
    s_gen++;
  endtask

  task automatic start_xfer(logic [31:0] s, logic [31:0] d, logic [15:0] l);
    drive_pt();
    cfg_src_adr = s; cfg_dst_adr = d; cfg_len = l; cfg_start = 1'b1; rd_src = s;
    drive_pt();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done_cnt > db) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rx(int n, int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (rx_n - rb >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({busy, done, dma_stb_o, dma_cyc_o, dma_we_o} !== 5'b0) begin n_bad++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, dma_stb_o, dma_cyc_o, dma_we_o}); end
    n_cmp++; if ({dma_sel_o, dma_adr_o, dma_dat_o} !== 68'h0) begin n_bad++;
      $display("FAIL reset_bus: sel %h adr %h dat %h expected all 0", dma_sel_o, dma_adr_o, dma_dat_o); end
    n_cmp++; if ({mm2s_tvalid, mm2s_tlast, mm2s_tdata} !== 34'h0) begin n_bad++;
      $display("FAIL reset_mm2s: valid %b last %b data %h expected 0", mm2s_tvalid, mm2s_tlast, mm2s_tdata); end
    n_cmp++; if (s2mm_tready !== 1'b0) begin n_bad++;
      $display("FAIL reset_s2mm_tready: got %b expected 0", s2mm_tready); end
    drive_pt();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, s2mm_tready, dma_stb_o} !== 3'b0) begin n_bad++;
      $display("FAIL idle_after_reset: got %b expected 000", {busy, s2mm_tready, dma_stb_o}); end
  endtask

  task automatic test_zero_len();
    mark();
    start_xfer(32'h40, 32'h80, 16'd0);
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++;
      $display("FAIL zero_len_cycle1: busy,done %b expected 10", {busy, done}); end
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b01) begin n_bad++;
      $display("FAIL zero_len_cycle2: busy,done %b expected 01", {busy, done}); end
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++;
      $display("FAIL zero_len_cycle3: busy,done %b expected 00", {busy, done}); end
    repeat (5) @(negedge clk);
    n_cmp++; if (done_cnt - db !== 1) begin n_bad++;
      $display("FAIL zero_len_done_count: got %0d expected 1", done_cnt - db); end
    n_cmp++; if ((stb_seen - sb) !== 0 || (tvalid_seen - vb) !== 0) begin n_bad++;
      $display("FAIL zero_len_activity: stb %0d tvalid %0d expected 0 0", stb_seen - sb, tvalid_seen - vb); end
  endtask

  task automatic test_mm2s_then_s2mm();
    logic [31:0] exp_rd [3] = '{32'h100, 32'h104, 32'h108};
    logic [31:0] exp_wr [3] = '{32'h200, 32'h204, 32'h208};
    logic [31:0] exp_dt [3] = '{32'hA0, 32'hA1, 32'hA2};
    logic [31:0] exp_wd [3] = '{32'hB0, 32'hB1, 32'hB2};
    bit ok;
    drive_pt();
    mark(); mm2s_tready = 1'b1; rd_base = 32'hA0; ack_delay = 0;
    start_xfer(32'h100, 32'h200, 16'd3);
    wait_rx(3, 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mm2s_timeout: got %0d beats expected 3", rx_n - rb); end
    repeat (10) @(negedge clk);
    n_cmp++; if (log_n - lb !== 3) begin n_bad++;
      $display("FAIL mm2s_read_count: got %0d expected 3", log_n - lb); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({log_adr[lb+i], log_we[lb+i], log_sel[lb+i]} !== {exp_rd[i], 1'b0, 4'hF}) begin n_bad++;
        $display("FAIL mm2s_read_%0d: adr %h we %b sel %h expected %h 0 f", i, log_adr[lb+i], log_we[lb+i], log_sel[lb+i], exp_rd[i]); end
      n_cmp++; if ({rx_dat[rb+i], rx_last[rb+i]} !== {exp_dt[i], i == 2}) begin n_bad++;
        $display("FAIL mm2s_beat_%0d: data %h last %b expected %h %b", i, rx_dat[rb+i], rx_last[rb+i], exp_dt[i], i == 2); end
    end
    n_cmp++; if ({done_cnt - db, busy} !== {32'd0, 1'b1}) begin n_bad++;
      $display("FAIL mm2s_no_done: done_count %0d busy %b expected 0 1", done_cnt - db, busy); end
    drive_pt();
    load_src(3, 32'hB0);
    wait_done(100, ok);
    n_cmp++; if (!ok || log_n - lb !== 6) begin n_bad++;
      $display("FAIL s2mm_done: seen %b txns %0d expected 1 6", ok, log_n - lb); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({log_adr[lb+3+i], log_we[lb+3+i], log_sel[lb+3+i], log_dat[lb+3+i]} !== {exp_wr[i], 1'b1, 4'hF, exp_wd[i]}) begin n_bad++;
        $display("FAIL s2mm_write_%0d: adr %h we %b sel %h dat %h expected %h 1 f %h", i, log_adr[lb+3+i], log_we[lb+3+i], log_sel[lb+3+i], log_dat[lb+3+i], exp_wr[i], exp_wd[i]); end
    end
    repeat (5) @(negedge clk);
    n_cmp++; if ({done_cnt - db, busy} !== {32'd1, 1'b0}) begin n_bad++;
      $display("FAIL s2mm_done_once: done_count %0d busy %b expected 1 0", done_cnt - db, busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_adr [6] = '{32'h500, 32'h600, 32'h504, 32'h604, 32'h508, 32'h608};
    logic        exp_we  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bit ok;
    drive_pt();
    mark(); mm2s_tready = 1'b1; rd_base = 32'h50; ack_delay = 0;
    load_src(3, 32'h30);
    start_xfer(32'h500, 32'h600, 16'd3);
    wait_done(200, ok);
    n_cmp++; if (!ok || log_n - lb !== 6) begin n_bad++;
      $display("FAIL b2b_done: seen %b txns %0d expected 1 6", ok, log_n - lb); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if ({log_adr[lb+i], log_we[lb+i]} !== {exp_adr[i], exp_we[i]}) begin n_bad++;
        $display("FAIL b2b_order_%0d: adr %h we %b expected %h %b", i, log_adr[lb+i], log_we[lb+i], exp_adr[i], exp_we[i]); end
    end
    n_cmp++; if ({log_dat[lb+1], log_dat[lb+3], log_dat[lb+5]} !== {32'h30, 32'h31, 32'h32}) begin n_bad++;
      $display("FAIL b2b_wdata: %h %h %h expected 30 31 32", log_dat[lb+1], log_dat[lb+3], log_dat[lb+5]); end
    n_cmp++; if ({rx_n - rb, rx_dat[rb+2], rx_last[rb+2], prot_viol - pb} !== {32'd3, 32'h52, 1'b1, 32'd0}) begin n_bad++;
      $display("FAIL b2b_stream: beats %0d last_data %h tlast %b viol %0d expected 3 52 1 0", rx_n - rb, rx_dat[rb+2], rx_last[rb+2], prot_viol - pb); end
  endtask

  task automatic test_backpressure();
    bit ok;
    drive_pt();
    mark(); mm2s_tready = 1'b0; rd_base = 32'hC0; ack_delay = 0;
    start_xfer(32'h400, 32'h800, 16'd8);
    repeat (60) @(negedge clk);
    n_cmp++; if ({log_n - lb, rx_n - rb} !== {32'd4, 32'd0}) begin n_bad++;
      $display("FAIL bp_reads_stalled: reads %0d beats %0d expected 4 0", log_n - lb, rx_n - rb); end
    n_cmp++; if ({dma_stb_o, mm2s_tvalid} !== 2'b01) begin n_bad++;
      $display("FAIL bp_idle_bus: stb %b tvalid %b expected 0 1", dma_stb_o, mm2s_tvalid); end
    drive_pt();
    mm2s_tready = 1'b1;
    wait_rx(8, 200, ok);
    n_cmp++; if (!ok || log_n - lb !== 8) begin n_bad++;
      $display("FAIL bp_resume: beats %0d reads %0d expected 8 8", rx_n - rb, log_n - lb); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if ({rx_dat[rb+i], rx_last[rb+i], log_adr[lb+i], log_we[lb+i]} !==
                   {32'hC0 + 32'(i), i == 7, 32'h400 + 32'(4*i), 1'b0}) begin n_bad++;
        $display("FAIL bp_beat_%0d: data %h last %b adr %h we %b expected %h %b %h 0", i, rx_dat[rb+i], rx_last[rb+i], log_adr[lb+i], log_we[lb+i], 32'hC0 + 32'(i), i == 7, 32'h400 + 32'(4*i)); end
    end
    drive_pt();
    load_src(8, 32'hD0);
    wait_done(300, ok);
    n_cmp++; if (!ok || log_n - lb !== 16) begin n_bad++;
      $display("FAIL bp_writes_done: seen %b txns %0d expected 1 16", ok, log_n - lb); end
    n_cmp++; if ({log_adr[lb+15], log_we[lb+15], log_dat[lb+15]} !== {32'h81C, 1'b1, 32'hD7}) begin n_bad++;
      $display("FAIL bp_last_write: adr %h we %b dat %h expected 81c 1 d7", log_adr[lb+15], log_we[lb+15], log_dat[lb+15]); end
  endtask

  task automatic test_ack_delay();
    logic [31:0] exp_adr [4] = '{32'h1000, 32'h2000, 32'h1004, 32'h2004};
    logic        exp_we  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit ok;
    drive_pt();
    mark(); mm2s_tready = 1'b1; rd_base = 32'hE0; ack_delay = 5;
    load_src(2, 32'hF0);
    start_xfer(32'h1000, 32'h2000, 16'd2);
    wait_done(300, ok);
    n_cmp++; if (!ok || log_n - lb !== 4) begin n_bad++;
      $display("FAIL delay_done: seen %b txns %0d expected 1 4", ok, log_n - lb); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({log_adr[lb+i], log_we[lb+i], log_wait[lb+i]} !== {exp_adr[i], exp_we[i], 32'd5}) begin n_bad++;
        $display("FAIL delay_txn_%0d: adr %h we %b wait %0d expected %h %b 5", i, log_adr[lb+i], log_we[lb+i], log_wait[lb+i], exp_adr[i], exp_we[i]); end
    end
    n_cmp++; if (prot_viol - pb !== 0) begin n_bad++;
      $display("FAIL delay_protocol: violations %0d expected 0", prot_viol - pb); end
    n_cmp++; if ({log_dat[lb+1], log_dat[lb+3], rx_dat[rb], rx_dat[rb+1], rx_last[rb+1]} !==
                 {32'hF0, 32'hF1, 32'hE0, 32'hE1, 1'b1}) begin n_bad++;
      $display("FAIL delay_data: wr %h %h rd %h %h last %b expected f0 f1 e0 e1 1", log_dat[lb+1], log_dat[lb+3], rx_dat[rb], rx_dat[rb+1], rx_last[rb+1]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    drive_pt();
    mark(); mm2s_tready = 1'b1; rd_base = 32'h10; ack_delay = 20;
    load_src(4, 32'h20);
    start_xfer(32'h3000, 32'h4000, 16'd4);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dma_stb_o && dma_we_o) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_wr_seen: got 0 expected 1"); end
    repeat (3) @(negedge clk);
    drive_pt();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({dma_stb_o, dma_cyc_o, busy, done, s2mm_tready, mm2s_tvalid} !== 6'b0) begin n_bad++;
      $display("FAIL rstmid_outputs: stb %b cyc %b busy %b done %b tready %b tvalid %b expected 0", dma_stb_o, dma_cyc_o, busy, done, s2mm_tready, mm2s_tvalid); end
    drive_pt();
    rst = 1'b0;
    load_src(0, 32'h0);
    repeat (10) @(negedge clk);
    n_cmp++; if ({done_cnt - db, dma_stb_o, busy} !== {32'd0, 1'b0, 1'b0}) begin n_bad++;
      $display("FAIL rstmid_no_done: done_count %0d stb %b busy %b expected 0 0 0", done_cnt - db, dma_stb_o, busy); end
    drive_pt();
    mark(); ack_delay = 0; rd_base = 32'h77;
    load_src(1, 32'h55);
    start_xfer(32'h300, 32'h340, 16'd1);
    wait_done(100, ok);
    n_cmp++; if (!ok || log_n - lb !== 2) begin n_bad++;
      $display("FAIL rstmid_rerun_done: seen %b txns %0d expected 1 2", ok, log_n - lb); end
    n_cmp++; if ({log_adr[lb], log_we[lb], log_adr[lb+1], log_we[lb+1], log_dat[lb+1]} !==
                 {32'h300, 1'b0, 32'h340, 1'b1, 32'h55}) begin n_bad++;
      $display("FAIL rstmid_rerun_bus: %h %b %h %b %h expected 300 0 340 1 55", log_adr[lb], log_we[lb], log_adr[lb+1], log_we[lb+1], log_dat[lb+1]); end
    n_cmp++; if ({rx_n - rb, rx_dat[rb], rx_last[rb]} !== {32'd1, 32'h77, 1'b1}) begin n_bad++;
      $display("FAIL rstmid_rerun_stream: beats %0d data %h last %b expected 1 77 1", rx_n - rb, rx_dat[rb], rx_last[rb]); end
    repeat (5) @(negedge clk);
    n_cmp++; if (done_cnt - db !== 1) begin n_bad++;
      $display("FAIL rstmid_rerun_done_once: got %0d expected 1", done_cnt - db); end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_mm2s_then_s2mm();
    test_back_to_back();
    test_backpressure();
    test_ack_delay();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dma_stream_engine.md
Name: dma_stream_engine

Overview:
- Wishbone DMA master sitting directly upstream of the SDRAM arbiter; its master port drives the arbiter's DMA-side inputs.
- Moves cfg_len 32-bit words between SDRAM and the accelerator:
  - MM2S: reads from cfg_src_adr and streams words out.
  - S2MM: accepts streamed words and writes them to cfg_dst_adr.
- Both channels share one single-outstanding Wishbone master, scheduled round-robin.

Parameters:
- LEN_W, 16, width of cfg_len (max transfer 2^LEN_W-1 words).
- FIFO_DEPTH, 4, MM2S read-buffer depth in words; power of 2, >=2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_start  in  1  one-cycle start pulse
- cfg_src_adr  in  32  SDRAM read base, byte address, word aligned
- cfg_dst_adr  in  32  SDRAM write base, byte address, word aligned
- cfg_len  in  LEN_W  words per direction
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- dma_stb_o  out  1  Wishbone strobe
- dma_cyc_o  out  1  Wishbone cycle
- dma_we_o  out  1  Wishbone write enable
- dma_sel_o  out  4  byte select
- dma_adr_o  out  32  Wishbone address
- dma_dat_o  out  32  write data
- dma_ack_i  in  1  acknowledge from arbiter
- dma_dat_i  in  32  read data from arbiter
- mm2s_tdata  out  32  stream to accelerator
- mm2s_tvalid  out  1  stream valid
- mm2s_tready  in  1  stream ready
- mm2s_tlast  out  1  last word of transfer
- s2mm_tdata  in  32  stream from accelerator
- s2mm_tvalid  in  1  stream valid
- s2mm_tready  out  1  stream ready

Behaviour:
- Reset: all outputs 0; FSM=IDLE; FIFO empty; counters 0; rr_last=WRITE, so the first tie goes to READ.
- Start: cfg_start in IDLE latches src, dst and len; busy=1 next cycle. cfg_start while busy is ignored.
- Zero length: cfg_len==0 gives busy=1 for exactly one cycle, then a done pulse. No bus or stream activity.
- FSM states: IDLE, SCHED, RD, WR, FIN.
- SCHED, eligibility:
  - read_ok = rd_issued<len and FIFO count + 0 outstanding < FIFO_DEPTH.
  - write_ok = wbuf_full.
  - Both eligible: grant the channel opposite rr_last; update rr_last on grant.
  - One eligible: grant it.
  - Neither eligible: stay in SCHED.
  - Completion: rd_issued==len, wr_done==len, FIFO empty and no mm2s beat pending, go to FIN.
- RD/WR bus cycle:
  - stb=cyc=1 asserted the cycle after the grant.
  - sel=4'hF; we=0 for RD, we=1 for WR.
  - adr = base + 4*index, 32-bit wrap. Index is rd_issued for RD, wr_done for WR.
  - adr, dat and we are held stable until the cycle dma_ack_i==1 is sampled; stb and cyc drop the following cycle.
  - No back-to-back stb: at least one SCHED cycle between transactions.
  - RD ack: push dma_dat_i into the FIFO; rd_issued++.
  - WR ack: clear wbuf; wr_done++.
  - Return to SCHED after either ack.
- dma_ack_i outside RD/WR is ignored.
- MM2S stream:
  - tvalid = FIFO not empty; tdata = FIFO head.
  - Pop on tvalid&tready.
  - tlast=1 on the beat where sent_cnt==len-1.
  - Simultaneous FIFO push (ack) and pop in the same cycle is legal; count unchanged.
- S2MM stream:
  - wbuf is a single register.
  - s2mm_tready = busy & !wbuf_full & (wr_accepted < len).
  - A beat loads wbuf; wr_accepted++.
  - Words beyond len are not accepted (tready stays 0).
- FIN: done=1 for one cycle; busy=0 from the next cycle; return to IDLE.
- Reset mid-transfer: stb/cyc drop the next cycle; FIFO and wbuf are discarded; no done pulse.
- Counters are LEN_W bits wide; the comparisons above prevent overflow.

Test Plan:
- Reset, then len=0 start -> busy high 1 cycle, done pulse once, stb never asserted, tvalid never asserted.
- src=0x100, len=3, tready=1, s2mm idle -> 3 reads at adr 0x100/0x104/0x108 with we=0, sel=F. SDRAM data 0xA0..0xA2 appear on mm2s in order, tlast on the third. No done, since writes are still pending.
- Previous plus accelerator sends 0xB0..0xB2 (dst=0x200) -> writes at 0x200/0x204/0x208 with dat B0..B2. Reads and writes alternate when both are eligible. done pulses once after the last ack.
- tready=0, len=8, FIFO_DEPTH=4 -> exactly 4 reads issued, then stb stays low. Raise tready -> remaining 4 reads complete with no data loss or reorder.
- Ack delayed 5 cycles per transaction -> adr/dat/we/stb stable across the wait. s2mm_tready low while wbuf is full.
- Assert rst during a WR wait-state -> stb/cyc low next cycle, busy=0, no done. A fresh start with len=1 then runs correctly.
